// File: rtl/maj_chain_seq.sv
// Bit-serial majority-carry chain: one MAJ stage per clock, result = XNOR(tap, carry_N).
// Optional MAJ_SEQ_EARLY_EXIT_EN: finish early once every remaining stage is a pass-through.
//
// state  | meaning
// S_IDLE | waiting for an operand set, in_ready=1
// S_RUN  | stepping the chain, one stage per clock
// S_DONE | result presented until the consumer takes it
module maj_chain_seq #(
  parameter  int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  op_a,
  input  logic [N-1:0]  op_b,
  input  logic          seed,
  input  logic          tap,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          result,
  output logic          busy,
  output logic [IW-1:0] stage
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic            tap_q, tap_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   stage_q, stage_d;

  logic            a_bit, b_bit, maj_bit, last_stage, pass_thru;

  assign a_bit      = a_q[stage_q];
  assign b_bit      = b_q[stage_q];
  assign maj_bit    = (carry_q & a_bit) | (carry_q & b_bit) | (a_bit & b_bit);
  assign last_stage = (stage_q == IW'(N - 1));

`ifdef MAJ_SEQ_EARLY_EXIT_EN
  // MAJ(c,1,0)=c, so once all remaining bit pairs differ the carry is final.
  logic [N-1:0] low_mask;
  always_comb begin
    low_mask = '0;
    for (int i = 0; i < N; i++) low_mask[i] = (i < int'(stage_q));
  end
  assign pass_thru = &((a_q ^ b_q) | low_mask);
`else
  assign pass_thru = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      tap_q   <= 1'b0;
      carry_q <= 1'b0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tap_q   <= tap_d;
      carry_q <= carry_d;
      stage_q <= stage_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    tap_d   = tap_q;
    carry_d = carry_q;
    stage_d = stage_q;
    if (flush) begin
      state_d = S_IDLE;
      carry_d = 1'b0;
      stage_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_d     = op_a;
            b_d     = op_b;
            tap_d   = tap;
            carry_d = seed;
            stage_d = '0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (pass_thru) begin
            stage_d = '0;
            state_d = S_DONE;
          end else begin
            carry_d = maj_bit;
            if (last_stage) begin
              stage_d = '0;
              state_d = S_DONE;
            end else begin
              stage_d = stage_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          stage_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_DONE);
    result    = (state_q == S_DONE) & ~(tap_q ^ carry_q);
    stage     = stage_q;
  end

endmodule

// File: tb/tb_maj_chain_seq.sv
// Self-checking bench for maj_chain_seq: directed cases plus randomized ops against a
// ripple-arithmetic reference model.
module tb_maj_chain_seq;
  localparam int N  = 8;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  op_a = '0;
  logic [N-1:0]  op_b = '0;
  logic          seed = 1'b0;
  logic          tap = 1'b0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          result;
  logic          busy;
  logic [IW-1:0] stage;

  int checks = 0;
  int errors = 0;

  maj_chain_seq #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .seed(seed), .tap(tap), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .busy(busy), .stage(stage)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Carry counted as a majority vote of three integer bits.
  function automatic logic ref_result(input logic [N-1:0] a, input logic [N-1:0] b,
                                      input logic s, input logic t);
    int c, sum;
    c = s ? 1 : 0;
    for (int i = 0; i < N; i++) begin
      sum = c + (a[i] ? 1 : 0) + (b[i] ? 1 : 0);
      c = (sum >= 2) ? 1 : 0;
    end
    return ((t ? 1 : 0) == c) ? 1'b1 : 1'b0;
  endfunction

  function automatic int ref_latency(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef MAJ_SEQ_EARLY_EXIT_EN
    for (int s = 0; s < N; s++) begin
      bit all_diff;
      all_diff = 1'b1;
      for (int j = s; j < N; j++) if (a[j] == b[j]) all_diff = 1'b0;
      if (all_diff) return s + 1;
    end
`endif
    return N;
  endfunction

  // Starts and ends just after a falling edge with the DUT idle.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                        input logic t, input int hold, input string name);
    int lat, exp_l;
    logic exp_r;
    exp_r = ref_result(a, b, s, t);
    exp_l = ref_latency(a, b);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_in_ready got %b want 1", name, in_ready);
    end
    op_a = a; op_b = b; seed = s; tap = t; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    op_a = N'($urandom); op_b = N'($urandom); seed = 1'($urandom); tap = 1'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 3 * N) begin
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || stage !== IW'(lat)) begin
        errors++;
        $display("FAIL %s run_state got busy=%b in_ready=%b stage=%0d want 1 0 %0d",
                 name, busy, in_ready, stage, lat);
      end
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== exp_l) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, lat, exp_l);
    end
    checks++;
    if (result !== exp_r) begin
      errors++;
      $display("FAIL %s result got %b want %b", name, result, exp_r);
    end
    repeat (hold) begin
      checks++;
      if (out_valid !== 1'b1 || result !== exp_r || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold got out_valid=%b result=%b in_ready=%b want 1 %b 0",
                 name, out_valid, result, in_ready, exp_r);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s post_handshake got out_valid=%b in_ready=%b busy=%b want 0 1 0",
               name, out_valid, in_ready, busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        result !== 1'b0 || stage !== '0) begin
      errors++;
      $display("FAIL reset got in_ready=%b out_valid=%b busy=%b result=%b stage=%0d want 1 0 0 0 0",
               in_ready, out_valid, busy, result, stage);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 0, "case1");
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 1, "case2");
    run_op(8'hF0, 8'h0F, 1'b1, 1'b1, 2, "case3");
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 5, "case4_hold");
  endtask

  task automatic wait_stage(input int target, input string name);
    int k;
    k = 0;
    while (stage !== IW'(target) && k < 2 * N) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (stage !== IW'(target)) begin
      errors++;
      $display("FAIL %s reach_stage got %0d want %0d", name, stage, target);
    end
  endtask

  task automatic test_flush_reset();
    op_a = 8'hAA; op_b = 8'hAA; seed = 1'b1; tap = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_stage(3, "flush");
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || stage !== '0) begin
      errors++;
      $display("FAIL flush_idle got busy=%b in_ready=%b out_valid=%b stage=%0d want 0 1 0 0",
               busy, in_ready, out_valid, stage);
    end
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_blocks_accept got busy=%b want 0", busy);
    end
    flush = 1'b0;
    op_a = 8'h3C; op_b = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    wait_stage(5, "reset_run");
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || stage !== '0 ||
        result !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_run got busy=%b in_ready=%b out_valid=%b stage=%0d result=%b want 0 1 0 0 0",
               busy, in_ready, out_valid, stage, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_result got out_valid=%b busy=%b want 0 0", out_valid, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a1, b1, a2, b2;
    logic s1, t1, s2, t2, r1, r2;
    int l1, l2, lat;
    a1 = N'($urandom); b1 = N'($urandom); s1 = 1'($urandom); t1 = 1'($urandom);
    a2 = N'($urandom); b2 = ~a2; s2 = 1'($urandom); t2 = 1'($urandom);
    r1 = ref_result(a1, b1, s1, t1); l1 = ref_latency(a1, b1);
    r2 = ref_result(a2, b2, s2, t2); l2 = ref_latency(a2, b2);
    op_a = a1; op_b = b1; seed = s1; tap = t1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    op_a = a2; op_b = b2; seed = s2; tap = t2;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 3 * N) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== l1 || result !== r1) begin
      errors++;
      $display("FAIL b2b_first got lat=%0d result=%b want %0d %b", lat, result, l1, r1);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_handshake got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || stage !== '0) begin
      errors++;
      $display("FAIL b2b_second_accept got busy=%b in_ready=%b stage=%0d want 1 0 0",
               busy, in_ready, stage);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 3 * N) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== l2 || result !== r2) begin
      errors++;
      $display("FAIL b2b_second got lat=%0d result=%b want %0d %b", lat, result, l2, r2);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_one_cycle_valid got out_valid=%b want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, m;
    int k;
    for (int n = 0; n < 30; n++) begin
      a = N'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        b = N'($urandom);
      end else begin
        k = $urandom_range(0, N);
        m = (k == 0) ? '0 : ({N{1'b1}} >> (N - k));
        b = ~a ^ (N'($urandom) & m);
      end
      run_op(a, b, 1'($urandom), 1'($urandom), $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
